axis_frame_length_check: RTL and testbench
==========================================

Name: axis_frame_length_check

Overview:
- Downstream consumer of a split header+payload frame interface: header beat carries pad, truncate, length and original_length; the payload is a separate AXI4-Stream.
- Pairs each header with exactly one payload frame and counts the payload bytes against the header length.
- Forwards the payload as a single AXI4-Stream, with error marking in tuser, or drops the frame.
- Emits one status pulse per frame; sits after the length-adjust stage, ahead of the MAC/encryption datapath.

Parameters:
- DATA_WIDTH, 64, payload tdata width in bits.
- KEEP_ENABLE, (DATA_WIDTH>8), use tkeep; if 0, every beat counts as KEEP_WIDTH bytes.
- KEEP_WIDTH, ((DATA_WIDTH+7)/8), tkeep width.
- USER_WIDTH, 1, tuser width; bit 0 is the error flag.

Ports:
- clk  in  1  clock
- rst_n  in  1  synchronous active-low reset
- s_axis_hdr_valid  in  1  header valid
- s_axis_hdr_ready  out  1  header ready
- s_axis_hdr_pad  in  1  frame was padded
- s_axis_hdr_truncate  in  1  frame was truncated
- s_axis_hdr_length  in  16  expected payload bytes
- s_axis_hdr_original_length  in  16  pre-adjust length (reported only)
- s_axis_tdata/tkeep/tvalid/tready/tlast/tuser  in/in/in/out/in/in  DATA_WIDTH/KEEP_WIDTH/1/1/1/USER_WIDTH  payload in
- m_axis_tdata/tkeep/tvalid/tready/tlast/tuser  out/out/out/in/out/out  same widths  payload out
- cfg_drop_truncated  in  1  discard frames whose header has truncate=1
- status_valid  out  1  one-cycle pulse per completed frame
- status_good, status_len_err, status_dropped  out  1 each  frame outcome
- status_pad, status_truncate  out  1 each  echo of header bits
- status_byte_count  out  16  counted payload bytes, saturating
- status_original_length  out  16  echo of header field

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset values: all valid/ready/status outputs 0; counters 0; FSM in IDLE. Reset mid-frame abandons the frame; no status is emitted for it.
- FSM states: IDLE, PASS, DROP.
- IDLE:
  - s_axis_hdr_ready=1 and s_axis_tready=0; payload never advances without a header.
  - On hdr handshake: latch all header fields and cfg_drop_truncated; clear byte counter.
  - Next state is DROP if truncate && cfg_drop_truncated, else PASS.
  - Header acceptance rate: at most one header per frame; the next header is accepted the cycle after return to IDLE.
- PASS:
  - Single-entry registered output stage; s_axis_tready = !m_axis_tvalid || m_axis_tready.
  - Latency 1 cycle; full throughput, one beat per cycle.
  - Beat bytes = popcount(tkeep) if KEEP_ENABLE, else KEEP_WIDTH.
  - Counter += beat bytes, saturating at 0xFFFF.
  - On the tlast beat: total = counter + beat bytes (saturating).
  - len_err = (total != latched length). Output tuser[0] = input tuser[0] | len_err on the last beat only; other tuser bits pass through.
  - Go to IDLE after the last beat is accepted into the output stage.
- DROP:
  - s_axis_tready=1; m_axis_tvalid is not asserted for frame beats.
  - Bytes are counted identically; go to IDLE on the tlast handshake.
- Status:
  - status_valid pulses the cycle after the input tlast handshake.
  - dropped=1 for DROP frames; len_err as computed (also reported when dropped).
  - good = !dropped && !len_err && !input_tuser_err.
- Boundaries:
  - Header length 0: always len_err unless every beat has tkeep=0.
  - A tkeep=0 beat counts 0 bytes and is forwarded.
  - Header and tlast in the same cycle are impossible by construction (IDLE blocks payload).
  - Output stalls (m_axis_tready=0) back-pressure the input; output data stays stable while valid.

Decomposition:
- Shared package: header field widths (16-bit length), status struct layout, tuser error bit index, FSM state enum.
- One natural sub-module, axis_keep_popcount: combinational tkeep to byte count, width $clog2(KEEP_WIDTH+1).

Test Plan:
- Header length=64, 8-beat frame with full tkeep, DATA_WIDTH=64 -> 8 beats out with latency 1; status good=1, byte_count=64, tuser[0]=0.
- Header length=60, last tkeep=0x0F -> good=1, byte_count=60; then length=64 with the same frame -> len_err=1, tuser[0]=1 on last beat only.
- Payload presented 5 cycles before the header -> s_axis_tready=0 until the cycle after the hdr handshake; no beats lost.
- truncate=1, cfg_drop_truncated=1, 4-beat frame -> no m_axis_tvalid; status dropped=1, truncate=1, byte_count=32.
- m_axis_tready toggling 1/0 every cycle over a 16-beat frame -> output order and data intact; status once; back-to-back second header accepted in the following IDLE.
- rst_n=0 for 1 cycle mid-PASS -> all outputs 0 next cycle, no status pulse; a fresh header and frame afterwards completes with good=1.

Source files
------------

// File: rtl/axis_frame_length_check_pkg.sv
// Shared definitions for the frame length checker.
// Holds the header length width, the tuser error bit position, the FSM
// state encoding, the per-frame status record and the tkeep counter width.
package axis_frame_length_check_pkg;

   localparam int LEN_W        = 16;
   localparam int USER_ERR_BIT = 0;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_PASS = 2'd1,
      ST_DROP = 2'd2
   } state_t;

   typedef struct packed {
      logic             good;
      logic             len_err;
      logic             dropped;
      logic             pad;
      logic             truncate;
      logic [LEN_W-1:0] byte_count;
      logic [LEN_W-1:0] original_length;
   } status_t;

   function automatic int keep_cnt_width(input int keep_width);
      return $clog2(keep_width + 1);
   endfunction

endpackage

// File: rtl/axis_keep_popcount.sv
// Combinational tkeep population count: number of valid bytes in a beat.
// Ports:
//   keep  - tkeep of the current beat
//   count - number of set bits in keep
module axis_keep_popcount
   import axis_frame_length_check_pkg::*;
#(
   parameter int KEEP_WIDTH = 8,
   parameter int CNT_W      = keep_cnt_width(KEEP_WIDTH)
) (
   input  logic [KEEP_WIDTH-1:0] keep,
   output logic [CNT_W-1:0]      count
);

   always_comb begin
      count = '0;
      for (int i = 0; i < KEEP_WIDTH; i++) begin
         count = count + CNT_W'(keep[i]);
      end
   end

endmodule

// File: rtl/axis_frame_length_check.sv
// Pairs each header beat with one payload frame, counts payload bytes against
// the header length, forwards the frame (error flag in tuser[0] on the last
// beat) or drops it, and emits one status pulse per completed frame.
// Ports:
//   clk, rst_n                 - clock, synchronous active-low reset
//   s_axis_hdr_*               - header: pad, truncate, length, original_length
//   s_axis_t*                  - payload in
//   m_axis_t*                  - payload out, one registered stage
//   cfg_drop_truncated         - discard frames whose header has truncate=1
//   status_*                   - per-frame outcome, valid for one cycle
module axis_frame_length_check
   import axis_frame_length_check_pkg::*;
#(
   parameter int DATA_WIDTH  = 64,
   parameter int KEEP_ENABLE = (DATA_WIDTH > 8),
   parameter int KEEP_WIDTH  = ((DATA_WIDTH + 7) / 8),
   parameter int USER_WIDTH  = 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  s_axis_hdr_valid,
   output logic                  s_axis_hdr_ready,
   input  logic                  s_axis_hdr_pad,
   input  logic                  s_axis_hdr_truncate,
   input  logic [15:0]           s_axis_hdr_length,
   input  logic [15:0]           s_axis_hdr_original_length,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   input  logic [KEEP_WIDTH-1:0] s_axis_tkeep,
   input  logic                  s_axis_tvalid,
   output logic                  s_axis_tready,
   input  logic                  s_axis_tlast,
   input  logic [USER_WIDTH-1:0] s_axis_tuser,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic                  m_axis_tlast,
   output logic [USER_WIDTH-1:0] m_axis_tuser,
   input  logic                  cfg_drop_truncated,
   output logic                  status_valid,
   output logic                  status_good,
   output logic                  status_len_err,
   output logic                  status_dropped,
   output logic                  status_pad,
   output logic                  status_truncate,
   output logic [15:0]           status_byte_count,
   output logic [15:0]           status_original_length
);

   localparam int CNT_W = keep_cnt_width(KEEP_WIDTH);

   state_t               state, state_nxt;
   logic [LEN_W-1:0]     len_q, orig_len_q, byte_cnt, total;
   logic                 pad_q, trunc_q;
   logic [CNT_W-1:0]     pop_cnt, beat_bytes;
   logic                 len_err, hdr_fire, in_fire, last_fire, pass_fire;
   logic [USER_WIDTH-1:0] user_nxt;

   logic [DATA_WIDTH-1:0] data_p1;
   logic [KEEP_WIDTH-1:0] keep_p1;
   logic                  last_p1, vld_p1;
   logic [USER_WIDTH-1:0] user_p1;
   status_t               status_p1;
   logic                  status_vld_p1;

   function automatic logic [LEN_W-1:0] sat_add(input logic [LEN_W-1:0] a,
                                                input logic [CNT_W-1:0] b);
      logic [LEN_W:0] s;
      s = {1'b0, a} + {{(LEN_W + 1 - CNT_W){1'b0}}, b};
      return s[LEN_W] ? '1 : s[LEN_W-1:0];
   endfunction

   axis_keep_popcount #(
      .KEEP_WIDTH (KEEP_WIDTH),
      .CNT_W      (CNT_W)
   ) u_popcount (
      .keep  (s_axis_tkeep),
      .count (pop_cnt)
   );

   assign beat_bytes = (KEEP_ENABLE != 0) ? pop_cnt : CNT_W'(KEEP_WIDTH);
   // Running total including the current beat; used on the tlast beat.
   assign total      = sat_add(byte_cnt, beat_bytes);
   assign len_err    = (total != len_q);

   always_ff @(posedge clk) begin
      if (!rst_n) state <= ST_IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt        = state;
      s_axis_hdr_ready = 1'b0;
      s_axis_tready    = 1'b0;
      case (state)
         ST_IDLE: begin
            // Held low while reset is asserted so no header slips in.
            s_axis_hdr_ready = rst_n;
            if (s_axis_hdr_valid && s_axis_hdr_ready)
               state_nxt = (s_axis_hdr_truncate && cfg_drop_truncated) ? ST_DROP : ST_PASS;
         end
         ST_PASS: begin
            s_axis_tready = !vld_p1 || m_axis_tready;
            if (s_axis_tvalid && s_axis_tready && s_axis_tlast) state_nxt = ST_IDLE;
         end
         ST_DROP: begin
            s_axis_tready = 1'b1;
            if (s_axis_tvalid && s_axis_tlast) state_nxt = ST_IDLE;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   assign hdr_fire  = s_axis_hdr_valid && s_axis_hdr_ready;
   assign in_fire   = s_axis_tvalid && s_axis_tready;
   assign last_fire = in_fire && s_axis_tlast;
   assign pass_fire = in_fire && (state == ST_PASS);

   always_comb begin
      user_nxt               = s_axis_tuser;
      user_nxt[USER_ERR_BIT] = s_axis_tuser[USER_ERR_BIT] | (s_axis_tlast && len_err);
   end

   // Stage p1: control (counter, output valid, status pulse)
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         byte_cnt      <= '0;
         vld_p1        <= 1'b0;
         status_vld_p1 <= 1'b0;
         status_p1     <= '0;
      end else begin
         if (hdr_fire)     byte_cnt <= '0;
         else if (in_fire) byte_cnt <= s_axis_tlast ? '0 : total;

         if (pass_fire)          vld_p1 <= 1'b1;
         else if (m_axis_tready) vld_p1 <= 1'b0;

         status_vld_p1 <= last_fire;
         if (last_fire) begin
            status_p1.good            <= (state != ST_DROP) && !len_err &&
                                         !s_axis_tuser[USER_ERR_BIT];
            status_p1.len_err         <= len_err;
            status_p1.dropped         <= (state == ST_DROP);
            status_p1.pad             <= pad_q;
            status_p1.truncate        <= trunc_q;
            status_p1.byte_count      <= total;
            status_p1.original_length <= orig_len_q;
         end
      end
   end

   // Stage p1: header latch and output beat data
   always_ff @(posedge clk) begin
      if (hdr_fire) begin
         len_q      <= s_axis_hdr_length;
         orig_len_q <= s_axis_hdr_original_length;
         pad_q      <= s_axis_hdr_pad;
         trunc_q    <= s_axis_hdr_truncate;
      end
      if (pass_fire) begin
         data_p1 <= s_axis_tdata;
         keep_p1 <= s_axis_tkeep;
         last_p1 <= s_axis_tlast;
         user_p1 <= user_nxt;
      end
   end

   assign m_axis_tdata           = data_p1;
   assign m_axis_tkeep           = keep_p1;
   assign m_axis_tvalid          = vld_p1;
   assign m_axis_tlast           = last_p1;
   assign m_axis_tuser           = user_p1;
   assign status_valid           = status_vld_p1;
   assign status_good            = status_p1.good;
   assign status_len_err         = status_p1.len_err;
   assign status_dropped         = status_p1.dropped;
   assign status_pad             = status_p1.pad;
   assign status_truncate        = status_p1.truncate;
   assign status_byte_count      = status_p1.byte_count;
   assign status_original_length = status_p1.original_length;

endmodule

// File: tb/tb_axis_frame_length_check.sv
// Directed bench for axis_frame_length_check: table of frames with expected
// status/tuser outcomes, plus a hand-written mid-frame reset sequence.
module tb_axis_frame_length_check;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        s_axis_hdr_valid, s_axis_hdr_ready, s_axis_hdr_pad, s_axis_hdr_truncate;
   logic [15:0] s_axis_hdr_length, s_axis_hdr_original_length;
   logic [63:0] s_axis_tdata, m_axis_tdata;
   logic [7:0]  s_axis_tkeep, m_axis_tkeep;
   logic        s_axis_tvalid, s_axis_tready, s_axis_tlast;
   logic [0:0]  s_axis_tuser, m_axis_tuser;
   logic        m_axis_tvalid, m_axis_tready, m_axis_tlast;
   logic        cfg_drop_truncated;
   logic        status_valid, status_good, status_len_err, status_dropped;
   logic        status_pad, status_truncate;
   logic [15:0] status_byte_count, status_original_length;

   always #5 clk = ~clk;

   axis_frame_length_check #(.DATA_WIDTH(64)) dut (
      .clk(clk), .rst_n(rst_n),
      .s_axis_hdr_valid(s_axis_hdr_valid), .s_axis_hdr_ready(s_axis_hdr_ready),
      .s_axis_hdr_pad(s_axis_hdr_pad), .s_axis_hdr_truncate(s_axis_hdr_truncate),
      .s_axis_hdr_length(s_axis_hdr_length),
      .s_axis_hdr_original_length(s_axis_hdr_original_length),
      .s_axis_tdata(s_axis_tdata), .s_axis_tkeep(s_axis_tkeep),
      .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready),
      .s_axis_tlast(s_axis_tlast), .s_axis_tuser(s_axis_tuser),
      .m_axis_tdata(m_axis_tdata), .m_axis_tkeep(m_axis_tkeep),
      .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
      .m_axis_tlast(m_axis_tlast), .m_axis_tuser(m_axis_tuser),
      .cfg_drop_truncated(cfg_drop_truncated),
      .status_valid(status_valid), .status_good(status_good),
      .status_len_err(status_len_err), .status_dropped(status_dropped),
      .status_pad(status_pad), .status_truncate(status_truncate),
      .status_byte_count(status_byte_count),
      .status_original_length(status_original_length)
   );

   typedef struct {
      int          pre;
      logic [15:0] len;
      logic        pad;
      logic        trunc;
      logic        cfg_drop;
      int          nbeats;
      logic [7:0]  last_keep;
      logic        user_err;
      logic        tog;
      logic        exp_good;
      logic        exp_len_err;
      logic        exp_drop;
      logic [15:0] exp_cnt;
      logic        exp_tuser;
   } vec_t;

   typedef struct packed {
      logic [63:0] data;
      logic [7:0]  keep;
      logic        last;
      logic        user;
   } beat_t;

   typedef struct packed {
      logic        good, len_err, dropped, pad, trunc;
      logic [15:0] cnt, orig;
   } st_t;

   vec_t  vecs [11];
   beat_t out_q [$];
   st_t   st_q [$];
   int    checks = 0;
   int    errors = 0;
   logic  tog_mode = 1'b0;

   always @(negedge clk) begin
      if (m_axis_tvalid && m_axis_tready)
         out_q.push_back('{m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser[0]});
      if (status_valid)
         st_q.push_back('{status_good, status_len_err, status_dropped, status_pad,
                          status_truncate, status_byte_count, status_original_length});
   end

   initial begin
      m_axis_tready = 1'b1;
      forever begin
         @(posedge clk);
         #1;
         if (tog_mode) m_axis_tready = ~m_axis_tready;
         else          m_axis_tready = 1'b1;
      end
   end

   initial begin
      #1000000;
      $display("FAIL watchdog expired checks=%0d", checks);
      $fatal(1, "simulation timeout");
   end

   task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h expected=%0h", name, got, exp);
      end
   endtask

   task automatic bound_expired(input string name);
      checks++;
      errors++;
      $display("FAIL %s got=timeout expected=handshake", name);
   endtask

   function automatic logic [63:0] pat(input int id, input int b);
      return {8'(id), 24'hA5C3E1, 32'(b) * 32'h01010101 + 32'h10};
   endfunction

   task automatic drive_beat(input vec_t v, input int id, input int b);
      s_axis_tdata = pat(id, b);
      s_axis_tkeep = (b == v.nbeats - 1) ? v.last_keep : 8'hFF;
      s_axis_tlast = (b == v.nbeats - 1);
      s_axis_tuser = (b == v.nbeats - 1) ? v.user_err : 1'b0;
   endtask

   task automatic send_frame(input vec_t v, input int id);
      int   ob, sb, waitc, n_out, last_i;
      logic hs;
      beat_t bt;
      st_t   st;
      ob = out_q.size();
      sb = st_q.size();
      tog_mode = v.tog;
      s_axis_hdr_pad             = v.pad;
      s_axis_hdr_truncate        = v.trunc;
      s_axis_hdr_length          = v.len;
      s_axis_hdr_original_length = v.len ^ 16'h1234;
      cfg_drop_truncated         = v.cfg_drop;
      if (v.pre > 0) begin
         drive_beat(v, id, 0);
         s_axis_tvalid = 1'b1;
         for (int i = 0; i < v.pre; i++) begin
            @(negedge clk);
            chk("early_tready", 64'(s_axis_tready), 64'd0);
            @(posedge clk);
            #1;
         end
      end
      s_axis_hdr_valid = 1'b1;
      hs = 1'b0;
      waitc = 0;
      while (!hs && waitc < 50) begin
         @(negedge clk);
         hs = s_axis_hdr_ready;
         if (hs) chk("hdr_cycle_tready", 64'(s_axis_tready), 64'd0);
         @(posedge clk);
         #1;
         waitc++;
      end
      s_axis_hdr_valid = 1'b0;
      if (!hs) begin
         bound_expired("hdr_handshake");
         s_axis_tvalid = 1'b0;
         return;
      end
      for (int b = 0; b < v.nbeats; b++) begin
         drive_beat(v, id, b);
         s_axis_tvalid = 1'b1;
         hs = 1'b0;
         waitc = 0;
         while (!hs && waitc < 50) begin
            @(negedge clk);
            hs = s_axis_tready;
            @(posedge clk);
            #1;
            waitc++;
         end
         if (!hs) begin
            bound_expired("beat_handshake");
            s_axis_tvalid = 1'b0;
            return;
         end
         if (v.exp_drop) begin
            chk("drop_no_tvalid", 64'(m_axis_tvalid), 64'd0);
         end else begin
            chk("lat1_tvalid", 64'(m_axis_tvalid), 64'd1);
            chk("lat1_tdata", m_axis_tdata, pat(id, b));
         end
      end
      s_axis_tvalid = 1'b0;
      chk("hdr_ready_after_last", 64'(s_axis_hdr_ready), 64'd1);
      repeat (6) @(posedge clk);
      #1;
      n_out = v.exp_drop ? 0 : v.nbeats;
      last_i = v.nbeats - 1;
      chk("out_beat_count", 64'(out_q.size() - ob), 64'(n_out));
      for (int i = 0; i < n_out && ob + i < out_q.size(); i++) begin
         bt = out_q[ob + i];
         chk("out_tdata", bt.data, pat(id, i));
         chk("out_tkeep", 64'(bt.keep), 64'((i == last_i) ? v.last_keep : 8'hFF));
         chk("out_tlast", 64'(bt.last), 64'(i == last_i));
         chk("out_tuser", 64'(bt.user), 64'((i == last_i) ? v.exp_tuser : 1'b0));
      end
      chk("status_pulses", 64'(st_q.size() - sb), 64'd1);
      if (st_q.size() > sb) begin
         st = st_q[sb];
         chk("st_good", 64'(st.good), 64'(v.exp_good));
         chk("st_len_err", 64'(st.len_err), 64'(v.exp_len_err));
         chk("st_dropped", 64'(st.dropped), 64'(v.exp_drop));
         chk("st_pad", 64'(st.pad), 64'(v.pad));
         chk("st_truncate", 64'(st.trunc), 64'(v.trunc));
         chk("st_byte_count", 64'(st.cnt), 64'(v.exp_cnt));
         chk("st_orig_len", 64'(st.orig), 64'(v.len ^ 16'h1234));
      end
   endtask

   initial begin
      int sb;
      rst_n = 1'b0;
      s_axis_hdr_valid = 1'b0;
      s_axis_hdr_pad = 1'b0;
      s_axis_hdr_truncate = 1'b0;
      s_axis_hdr_length = 16'd0;
      s_axis_hdr_original_length = 16'd0;
      s_axis_tvalid = 1'b0;
      s_axis_tdata = 64'd0;
      s_axis_tkeep = 8'd0;
      s_axis_tlast = 1'b0;
      s_axis_tuser = 1'b0;
      cfg_drop_truncated = 1'b0;

      //           pre len     pad   trunc cfg   n   keep   uerr  tog   good  lerr  drop  cnt      tuser
      vecs[0]  = '{0, 16'd64,  1'b0, 1'b0, 1'b0, 8,  8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd64,  1'b0};
      vecs[1]  = '{5, 16'd60,  1'b0, 1'b0, 1'b0, 8,  8'h0F, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd60,  1'b0};
      vecs[2]  = '{0, 16'd64,  1'b0, 1'b0, 1'b0, 8,  8'h0F, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd60,  1'b1};
      vecs[3]  = '{0, 16'd32,  1'b0, 1'b1, 1'b1, 4,  8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 16'd32,  1'b0};
      vecs[4]  = '{0, 16'd128, 1'b0, 1'b0, 1'b0, 16, 8'hFF, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'd128, 1'b0};
      vecs[5]  = '{0, 16'd8,   1'b1, 1'b0, 1'b0, 1,  8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd8,   1'b0};
      vecs[6]  = '{0, 16'd0,   1'b0, 1'b0, 1'b0, 1,  8'h00, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd0,   1'b0};
      vecs[7]  = '{0, 16'd0,   1'b0, 1'b0, 1'b0, 1,  8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 16'd1,   1'b1};
      vecs[8]  = '{0, 16'd16,  1'b0, 1'b0, 1'b0, 2,  8'hFF, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'd16,  1'b1};
      vecs[9]  = '{0, 16'd24,  1'b0, 1'b1, 1'b0, 3,  8'hFF, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 16'd24,  1'b0};
      vecs[10] = '{0, 16'd20,  1'b0, 1'b1, 1'b1, 3,  8'h0F, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 16'd20,  1'b0};

      repeat (3) @(posedge clk);
      #1;
      chk("rst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("rst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("rst_hdr_ready", 64'(s_axis_hdr_ready), 64'd0);
      chk("rst_status_valid", 64'(status_valid), 64'd0);
      chk("rst_status_count", 64'(status_byte_count), 64'd0);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      chk("idle_hdr_ready", 64'(s_axis_hdr_ready), 64'd1);

      for (int i = 0; i < 11; i++) send_frame(vecs[i], i);

      // Reset in the middle of a forwarded frame.
      tog_mode = 1'b0;
      sb = st_q.size();
      s_axis_hdr_pad = 1'b0;
      s_axis_hdr_truncate = 1'b0;
      s_axis_hdr_length = 16'd64;
      cfg_drop_truncated = 1'b0;
      s_axis_hdr_valid = 1'b1;
      @(negedge clk);
      chk("midrst_hdr_ready", 64'(s_axis_hdr_ready), 64'd1);
      @(posedge clk);
      #1;
      s_axis_hdr_valid = 1'b0;
      for (int b = 0; b < 3; b++) begin
         s_axis_tdata = pat(20, b);
         s_axis_tkeep = 8'hFF;
         s_axis_tlast = 1'b0;
         s_axis_tuser = 1'b0;
         s_axis_tvalid = 1'b1;
         @(negedge clk);
         chk("midrst_tready", 64'(s_axis_tready), 64'd1);
         @(posedge clk);
         #1;
      end
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_m_tvalid", 64'(m_axis_tvalid), 64'd0);
      chk("midrst_s_tready", 64'(s_axis_tready), 64'd0);
      chk("midrst_hdr_ready", 64'(s_axis_hdr_ready), 64'd0);
      chk("midrst_status_valid", 64'(status_valid), 64'd0);
      rst_n = 1'b1;
      s_axis_tvalid = 1'b0;
      repeat (5) @(posedge clk);
      #1;
      chk("midrst_no_status", 64'(st_q.size() - sb), 64'd0);
      send_frame(vecs[0], 21);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
